// File: rtl/delay_line_server_if.sv
// Request/response bus between the handle arbiter (master) and the delay-line server (slave).
interface delay_line_server_if #(
    parameter int DATA_W   = 16,
    parameter int HANDLE_W = 4
);
    logic                req;
    logic [DATA_W:0]     req_data;
    logic [HANDLE_W-1:0] req_handle;
    logic [DATA_W-1:0]   server_data;
    logic                server_ready;

    modport master (output req, output req_data, output req_handle,
                    input  server_data, input server_ready);
    modport slave  (input  req, input req_data, input req_handle,
                    output server_data, output server_ready);
endinterface

// File: rtl/delay_line_server.sv
// Per-handle circular delay lines in one RAM; one request in flight, response pulse two edges after ADDR.
// Optional macro DELAY_LINE_SERVER_CLAMP_EN: reads with delay >= len are clamped to the oldest sample.
module delay_line_server #(
    parameter int DATA_W   = 16,
    parameter int HANDLE_W = 4,
    parameter int ADDR_W   = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    delay_line_server_if.slave  bus,
    input  logic                cfg_write_i,
    input  logic [HANDLE_W-1:0] cfg_handle_i,
    input  logic [ADDR_W-1:0]   cfg_base_i,
    input  logic [ADDR_W-1:0]   cfg_len_i,
    output logic                err_overlap_o
);
    localparam int NH    = 2**HANDLE_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic signed [ADDR_W:0] ONE_S = 1;

    typedef enum logic [1:0] {IDLE, ADDR, MEM, RESP} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [ADDR_W-1:0]   base_q [NH];
    logic [ADDR_W-1:0]   len_q  [NH];
    logic [ADDR_W-1:0]   wptr_q [NH];

    logic                op_q, skip_q, stale_q, ready_q, err_q;
    logic [DATA_W-1:0]   pay_q, server_data_q;
    logic [HANDLE_W-1:0] hdl_q;
    logic [ADDR_W-1:0]   lbase_q, llen_q, lwptr_q, addr_q;

    logic [ADDR_W-1:0]   addr_d, dly, wptr_d;
    logic                skip_d, too_far;

    // idx = wptr - 1 - delay, wrapped once by len; delay < len is guaranteed by the caller
    function automatic logic [ADDR_W-1:0] read_index(input logic [ADDR_W-1:0] wptr,
                                                     input logic [ADDR_W-1:0] len,
                                                     input logic [ADDR_W-1:0] delay);
        logic signed [ADDR_W:0] idx;
        idx = $signed({1'b0, wptr}) - ONE_S - $signed({1'b0, delay});
        if (idx < 0)
            idx = idx + $signed({1'b0, len});
        return idx[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = ADDR;
            ADDR:    state_d = MEM;
            MEM:     state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        too_far = CW'(pay_q) >= CW'(llen_q);
        dly     = ADDR_W'(pay_q);
        skip_d  = (llen_q == '0);
        addr_d  = '0;
        if (op_q) begin
            addr_d = lbase_q + lwptr_q;
        end else begin
`ifdef DELAY_LINE_SERVER_CLAMP_EN
            if (too_far) dly = llen_q - ADDR_W'(1);
`else
            if (too_far) skip_d = 1'b1;
`endif
            addr_d = lbase_q + read_index(lwptr_q, llen_q, dly);
        end
        wptr_d = (lwptr_q == llen_q - ADDR_W'(1)) ? '0 : lwptr_q + ADDR_W'(1);
    end

    // ---- request latch (IDLE) / address (ADDR) / memory (MEM) / commit (RESP)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q          <= 1'b0;
            skip_q        <= 1'b0;
            stale_q       <= 1'b0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
            pay_q         <= '0;
            server_data_q <= '0;
            hdl_q         <= '0;
            lbase_q       <= '0;
            llen_q        <= '0;
            lwptr_q       <= '0;
            addr_q        <= '0;
            for (int i = 0; i < NH; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                wptr_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            if (bus.req && state_q != IDLE)
                err_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.req) begin
                    op_q    <= bus.req_data[DATA_W];
                    pay_q   <= bus.req_data[DATA_W-1:0];
                    hdl_q   <= bus.req_handle;
                    lbase_q <= base_q[bus.req_handle];
                    llen_q  <= len_q[bus.req_handle];
                    lwptr_q <= wptr_q[bus.req_handle];
                    stale_q <= cfg_write_i && (cfg_handle_i == bus.req_handle);
                end
                ADDR: begin
                    addr_q <= addr_d;
                    skip_q <= skip_d;
                end
                MEM: begin
                    ready_q       <= 1'b1;
                    server_data_q <= skip_q ? '0 : ram[addr_q];
                end
                default: if (op_q && !skip_q && !stale_q)
                    wptr_q[hdl_q] <= wptr_d;
            endcase
            // A reconfiguration of the in-flight handle invalidates its pointer commit
            if (state_q != IDLE && cfg_write_i && cfg_handle_i == hdl_q)
                stale_q <= 1'b1;
            if (cfg_write_i) begin
                base_q[cfg_handle_i] <= cfg_base_i;
                len_q[cfg_handle_i]  <= cfg_len_i;
                wptr_q[cfg_handle_i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && state_q == MEM && op_q && !skip_q)
            ram[addr_q] <= pay_q;
    end

    assign bus.server_data  = server_data_q;
    assign bus.server_ready = ready_q;
    assign err_overlap_o    = err_q;
endmodule

// File: tb/tb_delay_line_server.sv
// Directed bench for delay_line_server with a response scoreboard; honours DELAY_LINE_SERVER_CLAMP_EN.
module tb_delay_line_server;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_write;
    logic [3:0]  cfg_handle;
    logic [13:0] cfg_base, cfg_len;
    logic        err_overlap;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    delay_line_server_if #(.DATA_W(16), .HANDLE_W(4)) bus ();

    delay_line_server #(.DATA_W(16), .HANDLE_W(4), .ADDR_W(14)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .cfg_write_i  (cfg_write),
        .cfg_handle_i (cfg_handle),
        .cfg_base_i   (cfg_base),
        .cfg_len_i    (cfg_len),
        .err_overlap_o(err_overlap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] h, input logic [13:0] base, input logic [13:0] len);
        @(negedge clk);
        cfg_write = 1'b1; cfg_handle = h; cfg_base = base; cfg_len = len;
        @(negedge clk);
        cfg_write = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        logic [15:0] e;
        chk({tag, "_rdy3"}, 32'(bus.server_ready), 32'd1);
        if (bus.server_ready === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(bus.server_data), 32'(e));
        end
    endtask

    // Issue one request at edge N; ready must be low at N+1/N+2, high at N+3, low at N+4
    task automatic txn(input string tag, input logic op, input logic [3:0] h,
                       input logic [15:0] val, input logic [15:0] exp, input logic cfg_mid);
        @(negedge clk);
        bus.req = 1'b1; bus.req_data = {op, val}; bus.req_handle = h;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.req = 1'b0;
        if (cfg_mid) begin
            cfg_write = 1'b1; cfg_handle = h; cfg_base = 14'd100; cfg_len = 14'd4;
        end
        chk({tag, "_rdy1"}, 32'(bus.server_ready), 32'd0);
        @(negedge clk);
        cfg_write = 1'b0;
        chk({tag, "_rdy2"}, 32'(bus.server_ready), 32'd0);
        @(negedge clk);
        check_resp(tag);
        @(negedge clk);
        chk({tag, "_rdy4"}, 32'(bus.server_ready), 32'd0);
    endtask

    initial begin
        logic [15:0] far_exp;
        reset_n = 1'b0; cfg_write = 1'b0; cfg_handle = '0; cfg_base = '0; cfg_len = '0;
        bus.req = 1'b0; bus.req_data = '0; bus.req_handle = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.server_ready), 32'd0);
        chk("rst_data",  32'(bus.server_data),  32'd0);
        chk("rst_err",   32'(err_overlap),      32'd0);
        reset_n = 1'b1;

        cfg(4'd2, 14'd100, 14'd4);
        txn("w_a1", 1'b1, 4'd2, 16'h00A1, 16'h0000, 1'b0);
        txn("w_a2", 1'b1, 4'd2, 16'h00A2, 16'h0000, 1'b0);
        txn("w_a3", 1'b1, 4'd2, 16'h00A3, 16'h0000, 1'b0);
        txn("w_a4", 1'b1, 4'd2, 16'h00A4, 16'h0000, 1'b0);
        txn("w_a5", 1'b1, 4'd2, 16'h00A5, 16'h00A1, 1'b0);
        txn("r_d0", 1'b0, 4'd2, 16'd0, 16'h00A5, 1'b0);
        txn("r_d3", 1'b0, 4'd2, 16'd3, 16'h00A2, 1'b0);
        txn("r_d1", 1'b0, 4'd2, 16'd1, 16'h00A4, 1'b0);
`ifdef DELAY_LINE_SERVER_CLAMP_EN
        far_exp = 16'h00A2;
`else
        far_exp = 16'h0000;
`endif
        txn("r_d9", 1'b0, 4'd2, 16'd9, far_exp, 1'b0);

        // Line wrapping past the top of the address space
        cfg(4'd3, 14'd16383, 14'd3);
        txn("w_b1", 1'b1, 4'd3, 16'h00B1, 16'h0000, 1'b0);
        txn("w_b2", 1'b1, 4'd3, 16'h00B2, 16'h0000, 1'b0);
        txn("w_b3", 1'b1, 4'd3, 16'h00B3, 16'h0000, 1'b0);
        txn("w_b4", 1'b1, 4'd3, 16'h00B4, 16'h00B1, 1'b0);
        txn("r_b_d2", 1'b0, 4'd3, 16'd2, 16'h00B2, 1'b0);

        // Back-to-back strobe: second one dropped, sticky error
        @(negedge clk);
        bus.req = 1'b1; bus.req_data = {1'b0, 16'd0}; bus.req_handle = 4'd2;
        exp_q.push_back(16'h00A5);
        @(negedge clk);
        chk("ovl_rdy1", 32'(bus.server_ready), 32'd0);
        chk("ovl_err1", 32'(err_overlap), 32'd0);
        @(negedge clk);
        bus.req = 1'b0;
        chk("ovl_rdy2", 32'(bus.server_ready), 32'd0);
        chk("ovl_err2", 32'(err_overlap), 32'd1);
        @(negedge clk);
        check_resp("ovl");
        @(negedge clk);
        chk("ovl_rdy4", 32'(bus.server_ready), 32'd0);
        chk("ovl_sticky", 32'(err_overlap), 32'd1);

        // Disabled line aliasing h2's region must not touch RAM
        cfg(4'd5, 14'd100, 14'd0);
        txn("w_len0", 1'b1, 4'd5, 16'h0077, 16'h0000, 1'b0);
        txn("r_len0", 1'b0, 4'd5, 16'd0, 16'h0000, 1'b0);
        txn("r_keep0", 1'b0, 4'd2, 16'd0, 16'h00A5, 1'b0);
        txn("r_keep3", 1'b0, 4'd2, 16'd3, 16'h00A2, 1'b0);

        // Reset while a write is in flight
        @(negedge clk);
        bus.req = 1'b1; bus.req_data = {1'b1, 16'h00C1}; bus.req_handle = 4'd2;
        @(negedge clk);
        bus.req = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_rdy", 32'(bus.server_ready), 32'd0);
            @(negedge clk);
        end
        chk("abort_data", 32'(bus.server_data), 32'd0);
        chk("abort_err",  32'(err_overlap),     32'd0);

        cfg(4'd2, 14'd100, 14'd4);
        txn("w_d1", 1'b1, 4'd2, 16'h00D1, 16'h00A5, 1'b0);
        txn("r_d1v", 1'b0, 4'd2, 16'd0, 16'h00D1, 1'b0);
        txn("w_d2cfg", 1'b1, 4'd2, 16'h00D2, 16'h00A2, 1'b1);
        txn("w_d3", 1'b1, 4'd2, 16'h00D3, 16'h00D1, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
